// File: rtl/class_enumerator_if.sv
// Handshake bundle for class_enumerator: run control from the requester and
// the valid/ready value stream back to the consumer.
interface class_enumerator_if;
  logic       start;
  logic [1:0] target;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_value;
  logic       out_last;
  logic       done;
  logic [3:0] match_count;

  // Requester/consumer side: drives run control and the ready back-pressure.
  modport master (
    output start, target, out_ready,
    input  busy, out_valid, out_value, out_last, done, match_count
  );

  // Enumerator side.
  modport slave (
    input  start, target, out_ready,
    output busy, out_valid, out_value, out_last, done, match_count
  );
endinterface

// File: rtl/class_enumerator.sv
// class_enumerator: walks the 4-bit values 0..15 in ascending order and
// streams every value whose {prime, divisible-by-3} class equals the
// requested target, then pulses done. MAX_COUNT (0 = unlimited) caps the
// number of values emitted per run.
module class_enumerator #(
  parameter int MAX_COUNT = 0
) (
  input logic          clk,
  input logic          reset_n,
  class_enumerator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, OUT, DONE} state_t;

  // Bit v of each mask is the class bit of value v.
  // Primes: 2,3,5,7,11,13. Multiples of 3 (excluding 0): 3,6,9,12,15.
  localparam logic [15:0] PRIME_MASK = 16'h28AC;
  localparam logic [15:0] DIV3_MASK  = 16'h9248;

  localparam bit         LIMITED = (MAX_COUNT != 0);
  localparam logic [4:0] LIMIT   = 5'(MAX_COUNT);

  state_t     state, state_nxt;
  logic [3:0] idx, idx_nxt;
  logic [1:0] tgt, tgt_nxt;
  logic [3:0] value_q, value_nxt;
  logic       last_q, last_nxt;
  logic [3:0] count_q, count_nxt;
  logic       hit;
  logic       limit_hit;

  function automatic logic [1:0] class_of(input logic [3:0] v);
    return {PRIME_MASK[v], DIV3_MASK[v]};
  endfunction

  // Next-state and next-datapath logic for the scan/emit sequence.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    idx_nxt   = idx;
    tgt_nxt   = tgt;
    value_nxt = value_q;
    last_nxt  = last_q;
    count_nxt = count_q;
    hit       = (class_of(idx) == tgt);
    limit_hit = LIMITED && (({1'b0, count_q} + 5'd1) == LIMIT);

    case (state)
      IDLE: begin
        if (bus.start) begin
          tgt_nxt   = bus.target;
          idx_nxt   = 4'd0;
          count_nxt = 4'd0;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          value_nxt = idx;
          last_nxt  = (idx == 4'd15) || limit_hit;
          state_nxt = OUT;
        end else if (idx == 4'd15) begin
          state_nxt = DONE;
        end else begin
          idx_nxt = idx + 4'd1;
        end
      end
      OUT: begin
        // Value, valid and last stay frozen until the consumer takes them.
        if (bus.out_ready) begin
          count_nxt = count_q + 4'd1;
          last_nxt  = 1'b0;
          if (last_q) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + 4'd1;
            state_nxt = SCAN;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any pending output at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      idx     <= 4'd0;
      tgt     <= 2'd0;
      value_q <= 4'd0;
      last_q  <= 1'b0;
      count_q <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed before this edge, independent of statement order.
      state   <= state_nxt;
      idx     <= idx_nxt;
      tgt     <= tgt_nxt;
      value_q <= value_nxt;
      last_q  <= last_nxt;
      count_q <= count_nxt;
    end
  end

  // Status outputs decode directly from the state register.
  assign bus.busy        = (state != IDLE);
  assign bus.out_valid   = (state == OUT);
  assign bus.done        = (state == DONE);
  assign bus.out_value   = value_q;
  assign bus.out_last    = last_q;
  assign bus.match_count = count_q;

endmodule

// File: tb/tb_class_enumerator.sv
// Directed bench for class_enumerator. Two instances: unlimited and
// MAX_COUNT=2. Expected outputs come from an independent class model and
// are queued when a run starts, then popped as the DUT emits values.
module tb_class_enumerator;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_r;
  logic [1:0] target_r;
  logic       ready_r;
  logic       sel;

  int tests = 0;
  int fails = 0;

  logic [4:0] exp_q[$];

  class_enumerator_if ifc0 ();
  class_enumerator_if ifc2 ();

  assign ifc0.start     = start_r & ~sel;
  assign ifc0.target    = target_r;
  assign ifc0.out_ready = ready_r;
  assign ifc2.start     = start_r & sel;
  assign ifc2.target    = target_r;
  assign ifc2.out_ready = ready_r;

  class_enumerator #(.MAX_COUNT(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(ifc0));
  class_enumerator #(.MAX_COUNT(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(ifc2));

  always #5 clk = ~clk;

  // Outputs of whichever instance is currently under test.
  logic       o_busy, o_valid, o_last, o_done;
  logic [3:0] o_value, o_count;
  assign o_busy  = sel ? ifc2.busy        : ifc0.busy;
  assign o_valid = sel ? ifc2.out_valid   : ifc0.out_valid;
  assign o_last  = sel ? ifc2.out_last    : ifc0.out_last;
  assign o_done  = sel ? ifc2.done        : ifc0.done;
  assign o_value = sel ? ifc2.out_value   : ifc0.out_value;
  assign o_count = sel ? ifc2.match_count : ifc0.match_count;

  function automatic logic [1:0] model_class(input int v);
    bit p;
    bit d;
    p = (v == 2) || (v == 3) || (v == 5) || (v == 7) || (v == 11) || (v == 13);
    d = (v != 0) && ((v % 3) == 0);
    return {p, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One complete run: queue expectations, start, consume with optional
  // stalls and stray start pulses, then check the end-of-run behaviour.
  task automatic run(input bit s, input logic [1:0] tgt, input int maxc,
                     input int stall, input bit noisy);
    int         exp_n = 0;
    int         first_exp = -1;
    int         first_cyc = -1;
    int         cyc;
    int         waited = 0;
    bit         done_seen = 0;
    logic [4:0] held = '0;
    logic [4:0] e;

    sel      = s;
    target_r = tgt;
    ready_r  = 1'b1;
    for (int v = 0; v < 16; v++) begin
      if (model_class(v) == tgt && (maxc == 0 || exp_n < maxc)) begin
        exp_n++;
        exp_q.push_back({(v == 15) || (maxc != 0 && exp_n == maxc), 4'(v)});
        if (first_exp < 0) first_exp = v;
      end
    end
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    cyc = 0;
    check("busy_after_start", 32'(o_busy), 32'd1);

    while (cyc < 200) begin
      if (o_done) begin
        done_seen = 1;
        break;
      end
      if (o_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (waited == 0) held = {o_last, o_value};
        else check("stall_stable", 32'({o_last, o_value}), 32'(held));
        if (waited < stall) begin
          ready_r = 1'b0;
          waited++;
        end else begin
          ready_r = 1'b1;
          waited  = 0;
          if (exp_q.size() == 0) begin
            check("extra_output", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("out_value", 32'(o_value), 32'(e[3:0]));
            check("out_last", 32'(o_last), 32'(e[4]));
          end
        end
      end else begin
        ready_r = 1'($urandom_range(0, 1));
      end
      if (noisy) begin
        start_r  = ((cyc % 3) == 1);
        target_r = start_r ? ~tgt : tgt;
      end
      @(negedge clk);
      cyc++;
    end

    check("done_seen", 32'(done_seen), 32'd1);
    check("first_latency", 32'(first_cyc), 32'(first_exp + 1));
    check("match_count", 32'(o_count), 32'(exp_n));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("busy_in_done", 32'(o_busy), 32'd1);
    start_r = noisy;
    @(negedge clk);
    check("done_one_cycle", 32'(o_done), 32'd0);
    check("busy_after_done", 32'(o_busy), 32'd0);
    start_r  = 1'b0;
    target_r = tgt;
    ready_r  = 1'b1;
  endtask

  initial begin
    bit got5 = 0;

    reset_n  = 1'b0;
    start_r  = 1'b0;
    target_r = 2'b00;
    ready_r  = 1'b0;
    sel      = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy0", 32'(ifc0.busy), 32'd0);
    check("rst_valid0", 32'(ifc0.out_valid), 32'd0);
    check("rst_done0", 32'(ifc0.done), 32'd0);
    check("rst_last0", 32'(ifc0.out_last), 32'd0);
    check("rst_value0", 32'(ifc0.out_value), 32'd0);
    check("rst_count0", 32'(ifc0.match_count), 32'd0);
    check("rst_busy2", 32'(ifc2.busy), 32'd0);
    check("rst_valid2", 32'(ifc2.out_valid), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single member, scan runs on to 15; back-to-back restarts follow.
    run(1'b0, 2'b11, 0, 0, 1'b0);
    run(1'b0, 2'b01, 0, 0, 1'b0);
    run(1'b0, 2'b10, 0, 3, 1'b0);
    run(1'b0, 2'b00, 0, 0, 1'b0);
    // Capped run on the MAX_COUNT=2 instance.
    run(1'b1, 2'b00, 2, 0, 1'b0);
    // Stray starts and target toggles while busy are ignored.
    run(1'b0, 2'b01, 0, 1, 1'b1);

    // Asynchronous reset while value 5 is pending.
    sel      = 1'b0;
    target_r = 2'b10;
    ready_r  = 1'b1;
    start_r  = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (ifc0.out_valid && ifc0.out_value == 4'd5) begin
        got5    = 1;
        ready_r = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("rst_reached5", 32'(got5), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(ifc0.out_valid), 32'd0);
    check("arst_busy", 32'(ifc0.busy), 32'd0);
    check("arst_count", 32'(ifc0.match_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle_busy", 32'(ifc0.busy), 32'd0);
    check("post_rst_idle_valid", 32'(ifc0.out_valid), 32'd0);
    exp_q.delete();
    ready_r = 1'b1;
    run(1'b0, 2'b11, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
